// File: rtl/divisor_arbitrado_pkg.sv
// Shared types and helpers for the arbitrated divider front-end.
// Holds the FSM encoding, the divide-by-zero quotient and pointer wrap.
package divisor_arbitrado_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } estado_t;

    localparam int TAMANYO = 32;

    localparam logic [TAMANYO-1:0] DZ_COC = '1;

    // Circular increment for pointers whose modulus need not be 2^k.
    function automatic int unsigned wrap_inc(
        input int unsigned v,
        input int unsigned n
    );
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/divisor_arbitrado_if.sv
// Request and tagged response channels of the shared divider.
// Clients sit on the master side, the arbiter on the slave side.
interface divisor_arbitrado_if #(
    parameter int N_REQ   = 4,
    parameter int tamanyo = 32,
    parameter int IDW     = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ-1:0][tamanyo-1:0] req_num;
    logic [N_REQ-1:0][tamanyo-1:0] req_den;

    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [tamanyo-1:0] resp_coc;
    logic [tamanyo-1:0] resp_res;
    logic               resp_dz;

    modport master (
        output req_valid,
        output req_num,
        output req_den,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_coc,
        input  resp_res,
        input  resp_dz
    );

    modport slave (
        input  req_valid,
        input  req_num,
        input  req_den,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_coc,
        output resp_res,
        output resp_dz
    );

endinterface

// File: rtl/divisor_arbitrado_arbitro_rr.sv
// Combinational round-robin pick: first request at or after ptr.
// The pointer register itself is owned by the parent.
module arbitro_rr #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    logic [IDW:0]   suma;
    logic [IDW-1:0] k;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        suma = '0;
        k    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit so ptr+i never overflows before the wrap.
            suma = {1'b0, ptr} + (IDW+1)'(i);
            if (suma >= (IDW+1)'(N_REQ)) begin
                suma = suma - (IDW+1)'(N_REQ);
            end
            k = suma[IDW-1:0];
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/divisor_arbitrado.sv
// Shares one Start/Done divider among N_REQ requesters, round-robin.
// Zero divisors are answered locally so the divider never sees Den=0.
module divisor_arbitrado
    import divisor_arbitrado_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int tamanyo = 32,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                CLK,
    input  logic                RSTa,
    divisor_arbitrado_if.slave  bus,
    output logic                div_start,
    output logic [tamanyo-1:0]  div_num,
    output logic [tamanyo-1:0]  div_den,
    input  logic                div_done,
    input  logic [tamanyo-1:0]  div_coc,
    input  logic [tamanyo-1:0]  div_res
);

    estado_t estado;
    estado_t sig;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     idx;
    logic [N_REQ-1:0]   gnt;
    logic               any;
    logic               xfer;
    logic               den_cero;
    logic [tamanyo-1:0] num_g;
    logic [tamanyo-1:0] den_g;

    arbitro_rr #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign num_g    = bus.req_num[idx];
    assign den_g    = bus.req_den[idx];
    assign den_cero = (den_g == '0);
    assign xfer     = (estado == IDLE) && any;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            estado <= IDLE;
        end else begin
            estado <= sig;
        end
    end

    always_comb begin
        sig = estado;
        unique case (estado)
            IDLE: begin
                if (xfer) begin
                    sig = den_cero ? RESP : LAUNCH;
                end
            end
            LAUNCH: sig = WAIT;
            WAIT: begin
                if (div_done) begin
                    sig = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    sig = IDLE;
                end
            end
            default: sig = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (estado == IDLE) begin
            bus.req_ready = gnt;
        end
    end

    // Start and valid are registered from the next state so both
    // line up exactly with LAUNCH and RESP.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            div_start      <= 1'b0;
            bus.resp_valid <= 1'b0;
        end else begin
            div_start      <= (sig == LAUNCH);
            bus.resp_valid <= (sig == RESP);
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            div_num      <= '0;
            div_den      <= '0;
            bus.resp_id  <= '0;
            bus.resp_coc <= '0;
            bus.resp_res <= '0;
            bus.resp_dz  <= 1'b0;
            ptr          <= '0;
        end else begin
            if (xfer) begin
                bus.resp_id <= idx;
                if (den_cero) begin
                    bus.resp_coc <= {tamanyo{DZ_COC[0]}};
                    bus.resp_res <= num_g;
                    bus.resp_dz  <= 1'b1;
                end else begin
                    div_num <= num_g;
                    div_den <= den_g;
                end
            end
            if (estado == WAIT && div_done) begin
                bus.resp_coc <= div_coc;
                bus.resp_res <= div_res;
                bus.resp_dz  <= 1'b0;
            end
            // The served requester drops to lowest priority.
            if (estado == RESP && bus.resp_ready) begin
                ptr <= IDW'(wrap_inc(32'(bus.resp_id), 32'(N_REQ)));
            end
        end
    end

endmodule
